// File: rtl/catch_round_controller_pkg.sv
// Shared definitions for the fishing-game round controller: state encoding,
// lane geometry, screen constants and saturating score/timer helpers.
package catch_round_controller_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PLAY     = 3'd1,
      ST_HOOKED   = 3'd2,
      ST_REEL     = 3'd3,
      ST_SCORE    = 3'd4,
      ST_GAMEOVER = 3'd5
   } state_e;

   localparam logic [9:0] SURFACE_Y_C = 10'd155;
   localparam logic [9:0] V_TOTAL_C   = 10'd514;
   localparam logic [7:0] SCORE_MAX_C = 8'd255;

   // Index 0 is the deepest lane; deeper lanes are wider and easier to hit.
   localparam logic [3:0][9:0] LANE_Y_LO_C = {10'd197, 10'd285, 10'd372, 10'd460};
   localparam logic [3:0][9:0] LANE_Y_HI_C = {10'd203, 10'd295, 10'd388, 10'd480};
   localparam logic [3:0][9:0] LANE_W_C    = {10'd10,  10'd20,  10'd40,  10'd60};

   function automatic logic [7:0] score_add(input logic [7:0] s, input logic [1:0] lane);
      logic [8:0] sum;
      sum = {1'b0, s} + {7'd0, lane} + 9'd1;
      return sum[8] ? SCORE_MAX_C : sum[7:0];
   endfunction

   function automatic logic [7:0] dec_sat(input logic [7:0] v);
      return (v == 8'd0) ? 8'd0 : (v - 8'd1);
   endfunction

endpackage

// File: rtl/lane_hit_detect.sv
// Combinational catch test: reports whether the hook tip overlaps the shared
// fish x span within one of the four disjoint depth-lane y bands.
module lane_hit_detect
   import catch_round_controller_pkg::*;
(
   input  logic [9:0] hook_x_i,
   input  logic [9:0] hook_y_i,
   input  logic [9:0] fish_x_i,
   output logic       hit_o,
   output logic [1:0] lane_o
);

   // Bands never overlap, so at most one iteration can set the outputs.
   always_comb begin
      hit_o  = 1'b0;
      lane_o = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if ((hook_x_i >= fish_x_i) &&
             ({1'b0, hook_x_i} <= ({1'b0, fish_x_i} + {1'b0, LANE_W_C[i]})) &&
             (hook_y_i >= LANE_Y_LO_C[i]) && (hook_y_i <= LANE_Y_HI_C[i]) &&
             (hook_y_i < V_TOTAL_C)) begin
            hit_o  = 1'b1;
            lane_o = 2'(i);
         end else begin
            hit_o  = hit_o;
            lane_o = lane_o;
         end
      end
   end

endmodule

// File: rtl/catch_round_controller.sv
// Sequences one timed round: catch detection, hook lock, reeling, scoring and
// fish respawn. Define HIGH_SCORE_EN to add a persistent high_score output.
module catch_round_controller
   import catch_round_controller_pkg::*;
#(
   parameter int unsigned ROUND_TICKS = 240,
   parameter int unsigned HOOK_TICKS  = 8,
   parameter logic [9:0]  SURFACE_Y   = SURFACE_Y_C
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic [9:0] hook_x,
   input  logic [9:0] hook_y,
   input  logic [9:0] fish_x,
   output logic [2:0] state,
   output logic [7:0] score,
   output logic [7:0] time_left,
   output logic       hook_lock,
   output logic       reel_up,
   output logic       fish_respawn,
   output logic [1:0] caught_lane
`ifdef HIGH_SCORE_EN
   ,
   output logic [7:0] high_score
`endif
);

   state_e     state_q, state_d;
   logic [7:0] score_q, score_d;
   logic [7:0] time_q, time_d;
   logic [7:0] hcnt_q, hcnt_d;
   logic [1:0] lane_q, lane_d;
   logic       lock_q, lock_d;
   logic       reel_q, reel_d;
   logic       resp_q, resp_d;
   logic       start_q;
   logic       hit_s;
   logic [1:0] hit_lane_s;
   logic       start_edge_s;
   logic [7:0] new_score_s;
`ifdef HIGH_SCORE_EN
   logic [7:0] hs_q, hs_d;
`endif

   lane_hit_detect u_hit (
      .hook_x_i (hook_x),
      .hook_y_i (hook_y),
      .fish_x_i (fish_x),
      .hit_o    (hit_s),
      .lane_o   (hit_lane_s)
   );

   assign start_edge_s = start & ~start_q;
   assign new_score_s  = score_add(score_q, lane_q);

   // Next-state and registered-output logic for the round sequencer.
   always_comb begin
      state_d = state_q;
      score_d = score_q;
      time_d  = time_q;
      hcnt_d  = hcnt_q;
      lane_d  = lane_q;
      reel_d  = 1'b0;
      resp_d  = 1'b0;
`ifdef HIGH_SCORE_EN
      hs_d    = hs_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_edge_s) begin
               state_d = ST_PLAY;
               score_d = 8'd0;
               time_d  = 8'(ROUND_TICKS);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PLAY: begin
            // Expiry is checked first so a last-tick catch never scores.
            if (tick && (time_q == 8'd1)) begin
               time_d  = 8'd0;
               state_d = ST_GAMEOVER;
            end else if (tick) begin
               time_d = dec_sat(time_q);
               if (hit_s) begin
                  state_d = ST_HOOKED;
                  lane_d  = hit_lane_s;
                  hcnt_d  = 8'(HOOK_TICKS);
               end else begin
                  state_d = ST_PLAY;
               end
            end else begin
               state_d = ST_PLAY;
            end
         end
         ST_HOOKED: begin
            if (tick) begin
               time_d = dec_sat(time_q);
               hcnt_d = dec_sat(hcnt_q);
               state_d = (hcnt_q <= 8'd1) ? ST_REEL : ST_HOOKED;
            end else begin
               state_d = ST_HOOKED;
            end
         end
         ST_REEL: begin
            if (tick && (hook_y > SURFACE_Y)) begin
               time_d = dec_sat(time_q);
               reel_d = 1'b1;
            end else if (tick) begin
               time_d  = dec_sat(time_q);
               state_d = ST_SCORE;
               score_d = new_score_s;
               resp_d  = 1'b1;
`ifdef HIGH_SCORE_EN
               hs_d    = (new_score_s > hs_q) ? new_score_s : hs_q;
`endif
            end else begin
               state_d = ST_REEL;
            end
         end
         ST_SCORE: begin
            state_d = (time_q == 8'd0) ? ST_GAMEOVER : ST_PLAY;
         end
         ST_GAMEOVER: begin
            state_d = start_edge_s ? ST_IDLE : ST_GAMEOVER;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      lock_d = (state_d == ST_HOOKED) || (state_d == ST_REEL);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         score_q <= 8'd0;
         time_q  <= 8'd0;
         hcnt_q  <= 8'd0;
         lane_q  <= 2'd0;
         lock_q  <= 1'b0;
         reel_q  <= 1'b0;
         resp_q  <= 1'b0;
         start_q <= 1'b0;
`ifdef HIGH_SCORE_EN
         hs_q    <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         score_q <= score_d;
         time_q  <= time_d;
         hcnt_q  <= hcnt_d;
         lane_q  <= lane_d;
         lock_q  <= lock_d;
         reel_q  <= reel_d;
         resp_q  <= resp_d;
         start_q <= start;
`ifdef HIGH_SCORE_EN
         hs_q    <= hs_d;
`endif
      end
   end

   assign state        = state_q;
   assign score        = score_q;
   assign time_left    = time_q;
   assign hook_lock    = lock_q;
   assign reel_up      = reel_q;
   assign fish_respawn = resp_q;
   assign caught_lane  = lane_q;
`ifdef HIGH_SCORE_EN
   assign high_score   = hs_q;
`endif

endmodule

// File: tb/tb_catch_round_controller.sv
// Self-checking bench for catch_round_controller: directed round sequences,
// a lane-boundary vector table, randomized play against a reference model,
// and a saturation run on a short-hook instance.
module tb_catch_round_controller;

   localparam int ROUND = 240;
   localparam int HOOK  = 8;
   localparam int SURF  = 155;
   localparam int YLO [4] = '{460, 372, 285, 197};
   localparam int YHI [4] = '{480, 388, 295, 203};
   localparam int WID [4] = '{60, 40, 20, 10};
   localparam int P_IDLE = 0, P_PLAY = 1, P_HOOKED = 2, P_REEL = 3, P_SCORE = 4, P_OVER = 5;

   typedef struct { int dx; int y; int exp_state; int exp_lane; } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, tick, start;
   logic [9:0] hook_x, hook_y, fish_x;
   logic [2:0] state;
   logic [7:0] score, time_left;
   logic       hook_lock, reel_up, fish_respawn;
   logic [1:0] caught_lane;

   logic       s_rst, s_tick, s_start;
   logic [9:0] s_hook_x, s_hook_y, s_fish_x;
   logic [2:0] s_state;
   logic [7:0] s_score, s_time_left;
   logic       s_hook_lock, s_reel_up, s_fish_respawn;
   logic [1:0] s_caught_lane;
`ifdef HIGH_SCORE_EN
   logic [7:0] high_score, s_high_score;
`endif

   catch_round_controller u_dut (
      .clk(clk), .rst(rst), .tick(tick), .start(start),
      .hook_x(hook_x), .hook_y(hook_y), .fish_x(fish_x),
      .state(state), .score(score), .time_left(time_left),
      .hook_lock(hook_lock), .reel_up(reel_up), .fish_respawn(fish_respawn),
      .caught_lane(caught_lane)
`ifdef HIGH_SCORE_EN
      , .high_score(high_score)
`endif
   );

   catch_round_controller #(.ROUND_TICKS(255), .HOOK_TICKS(1)) u_sat (
      .clk(clk), .rst(s_rst), .tick(s_tick), .start(s_start),
      .hook_x(s_hook_x), .hook_y(s_hook_y), .fish_x(s_fish_x),
      .state(s_state), .score(s_score), .time_left(s_time_left),
      .hook_lock(s_hook_lock), .reel_up(s_reel_up), .fish_respawn(s_fish_respawn),
      .caught_lane(s_caught_lane)
`ifdef HIGH_SCORE_EN
      , .high_score(s_high_score)
`endif
   );

   int checks = 0;
   int errors = 0;
   int reel_cnt = 0;
   int resp_cnt = 0;
   int step = 2;
   int rb, n, expv, ln;
   vec_t vecs [18];

   // Reference model (spec-level round rules)
   int m_ph, m_score, m_time, m_lock, m_reel, m_resp, m_lane, m_hcnt, m_sprev, m_hs;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 60) $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lane_of(input int hx, input int hy, input int fx);
      for (int i = 0; i < 4; i++)
         if (hx >= fx && hx <= fx + WID[i] && hy >= YLO[i] && hy <= YHI[i]) return i;
      return -1;
   endfunction

   task automatic model_step();
      int edge_s, hl, ns;
      if (rst) begin
         m_ph = P_IDLE; m_score = 0; m_time = 0; m_lock = 0; m_reel = 0;
         m_resp = 0; m_lane = 0; m_hcnt = 0; m_sprev = 0; m_hs = 0;
         return;
      end
      edge_s = (start && m_sprev == 0) ? 1 : 0;
      m_sprev = int'(start);
      m_reel = 0; m_resp = 0;
      hl = lane_of(int'(hook_x), int'(hook_y), int'(fish_x));
      case (m_ph)
         P_IDLE: if (edge_s == 1) begin m_ph = P_PLAY; m_score = 0; m_time = ROUND; end
         P_PLAY: if (tick) begin
            if (m_time == 1) begin m_time = 0; m_ph = P_OVER; end
            else begin
               m_time--;
               if (hl >= 0) begin m_ph = P_HOOKED; m_lane = hl; m_hcnt = HOOK; end
            end
         end
         P_HOOKED: if (tick) begin
            if (m_time > 0) m_time--;
            m_hcnt--;
            if (m_hcnt <= 0) m_ph = P_REEL;
         end
         P_REEL: if (tick) begin
            if (m_time > 0) m_time--;
            if (int'(hook_y) > SURF) m_reel = 1;
            else begin
               ns = m_score + m_lane + 1;
               m_score = (ns > 255) ? 255 : ns;
               m_ph = P_SCORE; m_resp = 1;
               if (m_score > m_hs) m_hs = m_score;
            end
         end
         P_SCORE: m_ph = (m_time == 0) ? P_OVER : P_PLAY;
         default: if (edge_s == 1) m_ph = P_IDLE;
      endcase
      m_lock = (m_ph == P_HOOKED || m_ph == P_REEL) ? 1 : 0;
   endtask

   // One clock of the main DUT: advance model, compare, then act as renderer.
   task automatic cyc();
      model_step();
      @(negedge clk);
      chk("state", int'(state), m_ph);
      chk("score", int'(score), m_score);
      chk("time_left", int'(time_left), m_time);
      chk("hook_lock", int'(hook_lock), m_lock);
      chk("reel_up", int'(reel_up), m_reel);
      chk("fish_respawn", int'(fish_respawn), m_resp);
      chk("caught_lane", int'(caught_lane), m_lane);
`ifdef HIGH_SCORE_EN
      chk("high_score", int'(high_score), m_hs);
`endif
      if (reel_up) begin reel_cnt++; hook_y = hook_y - 10'(step); end
      if (fish_respawn) resp_cnt++;
   endtask

   task automatic tk();
      tick = 1'b1; cyc(); tick = 1'b0; cyc(); cyc();
   endtask

   task automatic press();
      start = 1'b1; cyc(); start = 1'b0; cyc();
   endtask

   task automatic do_reset();
      rst = 1'b1; cyc(); rst = 1'b0; cyc();
   endtask

   task automatic ticks_until(input int ph, input int limit, input string name);
      int k;
      k = 0;
      while (int'(state) != ph && k < limit) begin tk(); k++; end
      chk(name, int'(state), ph);
   endtask

   task automatic catch_at(input int dx, input int y);
      hook_x = 10'(int'(fish_x) + dx); hook_y = 10'(y);
      tk();
      ticks_until(P_REEL, 20, "catch_reel");
      hook_y = 10'd100;
      ticks_until(P_PLAY, 20, "catch_done");
   endtask

   task automatic stk();
      s_tick = 1'b1; @(negedge clk); s_tick = 1'b0; @(negedge clk); @(negedge clk);
   endtask

   initial begin
      vecs = '{'{0, 460, 2, 0}, '{60, 480, 2, 0}, '{61, 470, 1, 0}, '{-1, 470, 1, 0},
               '{30, 459, 1, 0}, '{30, 481, 1, 0}, '{40, 372, 2, 1}, '{41, 380, 1, 0},
               '{0, 388, 2, 1}, '{20, 371, 1, 0}, '{20, 285, 2, 2}, '{21, 290, 1, 0},
               '{10, 295, 2, 2}, '{10, 296, 1, 0}, '{10, 197, 2, 3}, '{5, 203, 2, 3},
               '{5, 196, 1, 0}, '{5, 204, 1, 0}};
      rst = 1'b1; tick = 1'b0; start = 1'b0;
      fish_x = 10'd300; hook_x = 10'd100; hook_y = 10'd100;
      s_rst = 1'b1; s_tick = 1'b0; s_start = 1'b0;
      s_fish_x = 10'd300; s_hook_x = 10'd0; s_hook_y = 10'd100;

      cyc(); cyc(); rst = 1'b0; cyc();
      chk("reset_state", int'(state), 0);
      chk("reset_time", int'(time_left), 0);

      start = 1'b1; cyc();
      chk("start_state", int'(state), 1);
      chk("start_time", int'(time_left), 240);
      chk("start_score", int'(score), 0);
      start = 1'b0; cyc();

      // Deep-lane catch, hook lock, then 2-pixel reel to the surface
      hook_x = fish_x + 10'd30; hook_y = 10'd470; tk();
      chk("hooked_state", int'(state), 2);
      chk("hooked_lane", int'(caught_lane), 0);
      chk("hooked_lock", int'(hook_lock), 1);
      for (int i = 0; i < 7; i++) tk();
      chk("hooked_after7", int'(state), 2);
      tk();
      chk("reel_after8", int'(state), 3);
      reel_cnt = 0; resp_cnt = 0;
      ticks_until(P_PLAY, 400, "reel_done");
      chk("reel_pulses", reel_cnt, 158);
      chk("reel_hook_y", int'(hook_y), 154);
      chk("score_lane0", int'(score), 1);
      chk("respawn_count", resp_cnt, 1);

      // Lane3 x boundary
      hook_y = 10'd200; hook_x = fish_x + 10'd11; tk();
      chk("lane3_miss", int'(state), 1);
      hook_x = fish_x + 10'd10; tk();
      chk("lane3_hit", int'(state), 2);
      chk("lane3_lane", int'(caught_lane), 3);
      ticks_until(P_REEL, 20, "lane3_reel");
      ticks_until(P_PLAY, 100, "lane3_done");
      chk("score_lane3", int'(score), 5);

      // Timeout wins over a same-tick hit
      hook_y = 10'd100; n = 0;
      while (int'(time_left) != 1 && n < 300) begin tk(); n++; end
      chk("time_at_1", int'(time_left), 1);
      hook_x = fish_x + 10'd30; hook_y = 10'd470; tk();
      chk("timeout_state", int'(state), 5);
      chk("timeout_time", int'(time_left), 0);
      chk("timeout_score", int'(score), 5);
      tk();
      chk("over_hold", int'(state), 5);
      press();
      chk("over_to_idle", int'(state), 0);
      press();
      chk("replay_state", int'(state), 1);
      chk("replay_score", int'(score), 0);

      // Reset in the middle of reeling
      tk();
      ticks_until(P_REEL, 20, "mid_reel");
      tk(); tk();
      rst = 1'b1; cyc();
      chk("rst_state", int'(state), 0);
      chk("rst_lock", int'(hook_lock), 0);
      chk("rst_time", int'(time_left), 0);
      chk("rst_reel", int'(reel_up), 0);
      rst = 1'b0; cyc();

      // Lane hit boundary table
      for (int v = 0; v < 18; v++) begin
         do_reset(); press();
         hook_x = 10'(int'(fish_x) + vecs[v].dx); hook_y = 10'(vecs[v].y);
         tk();
         chk($sformatf("vec%0d_state", v), int'(state), vecs[v].exp_state);
         if (vecs[v].exp_state == 2) chk($sformatf("vec%0d_lane", v), int'(caught_lane), vecs[v].exp_lane);
      end

`ifdef HIGH_SCORE_EN
      do_reset(); press();
      catch_at(5, 200); catch_at(30, 470);
      chk("hs_round1_score", int'(score), 5);
      hook_y = 10'd100;
      ticks_until(P_OVER, 300, "hs_round1_over");
      press(); press();
      catch_at(10, 290);
      chk("hs_round2_score", int'(score), 3);
      chk("hs_kept", int'(high_score), 5);
`endif

      // Randomized play against the model
      step = 8;
      do_reset();
      for (int c = 0; c < 15000; c++) begin
         rst  = ($urandom_range(0, 2999) == 0);
         tick = !tick && ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 59) == 0) start = !start;
         if (m_ph != P_REEL && $urandom_range(0, 7) == 0) begin
            rb = int'($urandom_range(0, 4));
            if (rb < 4) hook_y = 10'($urandom_range(YLO[rb] - 2, YHI[rb] + 2));
            else hook_y = 10'($urandom_range(0, 513));
            hook_x = 10'(int'(fish_x) + int'($urandom_range(0, 72)) - 3);
         end
         if ($urandom_range(0, 199) == 0) fish_x = 10'($urandom_range(0, 900));
         cyc();
      end

      // Saturation on the short-hook instance
      rst = 1'b1;
      @(negedge clk); @(negedge clk); s_rst = 1'b0; @(negedge clk);
      s_start = 1'b1; @(negedge clk); s_start = 1'b0; @(negedge clk);
      chk("sat_play", int'(s_state), 1);
      chk("sat_time", int'(s_time_left), 255);
      expv = 0;
      for (int k = 0; k < 65; k++) begin
         ln = (k == 63) ? 0 : 3;
         s_hook_x = s_fish_x + ((ln == 0) ? 10'd30 : 10'd5);
         s_hook_y = (ln == 0) ? 10'd470 : 10'd200;
         stk(); stk();
         s_hook_y = 10'd100;
         stk();
         expv = expv + ln + 1;
         if (expv > 255) expv = 255;
         if (k >= 62) chk($sformatf("sat_score%0d", k), int'(s_score), expv);
      end
      chk("sat_state", int'(s_state), 1);
      chk("sat_time_end", int'(s_time_left), 60);
      chk("sat_lane", int'(s_caught_lane), 3);
      chk("sat_lock", int'(s_hook_lock), 0);
      chk("sat_reel", int'(s_reel_up), 0);
      chk("sat_resp", int'(s_fish_respawn), 0);
`ifdef HIGH_SCORE_EN
      chk("sat_high", int'(s_high_score), 255);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
